// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the memory port arbiter: FSM states,
// requester ids and the fixed address/data widths.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FET = 2'd0,
    LSU = 2'd1,
    RMW = 2'd2
  } req_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: RMW write-back first, then fetch/LSU
// round-robin, with LSU masked by the RMW address lock.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic              fet_req,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic              lsu_rmw,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              rmw_req,
  input  logic              lock_active,
  input  logic [ADDR_W-1:0] lock_addr,
  input  logic              last_lsu,
  output req_id_t           grant_id,
  output logic              grant_valid
);

  logic lsu_ok;

  always_comb begin
    // Only one lock exists, so a second RMW load must wait as well.
    lsu_ok = lsu_req
             && !(lock_active && (lsu_addr == lock_addr))
             && !(lock_active && lsu_rmw && !lsu_we);
    grant_id    = FET;
    grant_valid = 1'b0;
    if (rmw_req) begin
      grant_id    = RMW;
      grant_valid = 1'b1;
    end else if (fet_req && lsu_ok) begin
      grant_id    = last_lsu ? FET : LSU;
      grant_valid = 1'b1;
    end else if (fet_req) begin
      grant_id    = FET;
      grant_valid = 1'b1;
    end else if (lsu_ok) begin
      grant_id    = LSU;
      grant_valid = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Owns the single memory port: one transaction at a time through
// IDLE/BUSY/ACK, plus the RMW address lock between read and write-back.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fet_req,
  input  logic [ADDR_W-1:0] fet_addr,
  output logic              fet_ack,
  output logic [DATA_W-1:0] fet_data,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic              lsu_rmw,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_ack,
  output logic [DATA_W-1:0] lsu_rdata,
  input  logic              rmw_req,
  input  logic [ADDR_W-1:0] rmw_addr,
  input  logic [DATA_W-1:0] rmw_data,
  output logic              rmw_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lock_active,
  output logic [ADDR_W-1:0] lock_addr
);

  state_t  state;
  req_id_t cur_id;
  req_id_t grant_id;
  logic    grant_valid;
  logic    last_lsu;
  logic    cur_rmw;

  mem_arb_pick u_pick (
    .fet_req    (fet_req),
    .lsu_req    (lsu_req),
    .lsu_we     (lsu_we),
    .lsu_rmw    (lsu_rmw),
    .lsu_addr   (lsu_addr),
    .rmw_req    (rmw_req),
    .lock_active(lock_active),
    .lock_addr  (lock_addr),
    .last_lsu   (last_lsu),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_id      <= FET;
      cur_rmw     <= 1'b0;
      last_lsu    <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      fet_ack     <= 1'b0;
      lsu_ack     <= 1'b0;
      rmw_ack     <= 1'b0;
      fet_data    <= '0;
      lsu_rdata   <= '0;
      lock_active <= 1'b0;
      lock_addr   <= '0;
    end else begin
      fet_ack <= 1'b0;
      lsu_ack <= 1'b0;
      rmw_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state   <= BUSY;
            cur_id  <= grant_id;
            mem_req <= 1'b1;
            case (grant_id)
              LSU: begin
                mem_addr  <= lsu_addr;
                mem_we    <= lsu_we;
                mem_wdata <= lsu_wdata;
                cur_rmw   <= lsu_rmw && !lsu_we;
                last_lsu  <= 1'b1;
              end
              RMW: begin
                mem_addr  <= rmw_addr;
                mem_we    <= 1'b1;
                mem_wdata <= rmw_data;
                cur_rmw   <= 1'b0;
              end
              default: begin
                mem_addr <= fet_addr;
                mem_we   <= 1'b0;
                cur_rmw  <= 1'b0;
                last_lsu <= 1'b0;
              end
            endcase
          end
        end
        BUSY: begin
          if (mem_rdy) begin
            state   <= ACK;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            case (cur_id)
              LSU: begin
                lsu_ack   <= 1'b1;
                lsu_rdata <= mem_rdata;
                if (cur_rmw) begin
                  lock_active <= 1'b1;
                  lock_addr   <= mem_addr;
                end
              end
              RMW: begin
                rmw_ack <= 1'b1;
                if (lock_active && (mem_addr == lock_addr))
                  lock_active <= 1'b0;
              end
              default: begin
                fet_ack  <= 1'b1;
                fet_data <= mem_rdata;
              end
            endcase
          end
        end
        // No arbitration here so a just-acked requester can drop its request.
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a small memory
// model that answers in the first BUSY cycle unless held off.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fet_req, lsu_req, lsu_we, lsu_rmw, rmw_req;
  logic [15:0] fet_addr, lsu_addr, lsu_wdata, rmw_addr, rmw_data;
  logic        fet_ack, lsu_ack, rmw_ack;
  logic [15:0] fet_data, lsu_rdata;
  logic        mem_req, mem_we, mem_rdy, lock_active;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, lock_addr;
  logic        auto_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        fet;
    logic [15:0] fa;
    logic        lsu, we, rmw;
    logic [15:0] la, lw;
    logic        rq;
    logic [15:0] ra, rd;
    logic [1:0]  exp_id;
    logic [15:0] exp_addr;
    logic        exp_we;
    logic [15:0] exp_wdata;
    logic        exp_lock;
    logic [15:0] exp_lock_addr;
  } vec_t;

  localparam logic [1:0] E_FET = 2'd0, E_LSU = 2'd1, E_RMW = 2'd2, E_STALL = 2'd3;

  vec_t vecs [22];

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .fet_req(fet_req), .fet_addr(fet_addr), .fet_ack(fet_ack), .fet_data(fet_data),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_rmw(lsu_rmw), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_ack(lsu_ack), .lsu_rdata(lsu_rdata),
    .rmw_req(rmw_req), .rmw_addr(rmw_addr), .rmw_data(rmw_data), .rmw_ack(rmw_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .lock_active(lock_active), .lock_addr(lock_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return (a == 16'h1000) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  always @(negedge clk) begin
    mem_rdy   = mem_req && auto_rdy;
    mem_rdata = mem_model(mem_addr);
  end

  function automatic vec_t mk(input logic fet, input logic [15:0] fa,
                              input logic lsu, input logic we, input logic rmw,
                              input logic [15:0] la, input logic [15:0] lw,
                              input logic rq, input logic [15:0] ra, input logic [15:0] rd,
                              input logic [1:0] eid, input logic [15:0] eaddr,
                              input logic ewe, input logic [15:0] ewdata,
                              input logic elock, input logic [15:0] eladdr);
    vec_t v;
    v = '{fet, fa, lsu, we, rmw, la, lw, rq, ra, rd, eid, eaddr, ewe, ewdata, elock, eladdr};
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    fet_req = v.fet; fet_addr = v.fa;
    lsu_req = v.lsu; lsu_we = v.we; lsu_rmw = v.rmw; lsu_addr = v.la; lsu_wdata = v.lw;
    rmw_req = v.rq;  rmw_addr = v.ra; rmw_data = v.rd;
  endtask

  task automatic drop_all();
    fet_req = 1'b0; lsu_req = 1'b0; rmw_req = 1'b0;
  endtask

  task automatic run_row(input int i);
    vec_t v;
    int   t;
    v = vecs[i];
    apply_stimulus(v);
    if (v.exp_id == E_STALL) begin
      repeat (4) @(negedge clk);
      check_output($sformatf("row%0d stall_req", i), 32'(mem_req), 32'd0);
      check_output($sformatf("row%0d lock", i), 32'(lock_active), 32'(v.exp_lock));
      return;
    end
    t = 0;
    while (!mem_req && t < 10) begin @(negedge clk); t++; end
    check_output($sformatf("row%0d grant_req", i), 32'(mem_req), 32'd1);
    check_output($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(v.exp_addr));
    check_output($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(v.exp_we));
    if (v.exp_we)
      check_output($sformatf("row%0d mem_wdata", i), 32'(mem_wdata), 32'(v.exp_wdata));
    t = 0;
    while (!(fet_ack || lsu_ack || rmw_ack) && t < 10) begin @(negedge clk); t++; end
    check_output($sformatf("row%0d ack_id", i), 32'({rmw_ack, lsu_ack, fet_ack}),
                 32'(3'b001 << v.exp_id));
    if (v.exp_id == E_FET)
      check_output($sformatf("row%0d fet_data", i), 32'(fet_data), 32'(mem_model(v.fa)));
    if (v.exp_id == E_LSU && !v.we)
      check_output($sformatf("row%0d lsu_rdata", i), 32'(lsu_rdata), 32'(mem_model(v.la)));
    check_output($sformatf("row%0d lock", i), 32'(lock_active), 32'(v.exp_lock));
    if (v.exp_lock)
      check_output($sformatf("row%0d lock_addr", i), 32'(lock_addr), 32'(v.exp_lock_addr));
    drop_all();
    @(negedge clk);
    check_output($sformatf("row%0d ack_pulse", i), 32'({rmw_ack, lsu_ack, fet_ack}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          t, ngr, last_cyc;
    logic        prev, ack_seen, stable;
    logic [15:0] gaddr [4];
    int          gcyc  [4];
    logic [15:0] want  [4];

    vecs[0]  = mk(1, 16'h1000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, E_FET,   16'h1000, 0, 16'h0000, 0, 16'h0000);
    vecs[1]  = mk(0, 16'h0000, 1, 0, 0, 16'h0300, 16'h0000, 0, 16'h0000, 16'h0000, E_LSU,   16'h0300, 0, 16'h0000, 0, 16'h0000);
    vecs[2]  = mk(1, 16'h1100, 1, 0, 0, 16'h0310, 16'h0000, 0, 16'h0000, 16'h0000, E_FET,   16'h1100, 0, 16'h0000, 0, 16'h0000);
    vecs[3]  = mk(1, 16'h1104, 1, 0, 0, 16'h0310, 16'h0000, 0, 16'h0000, 16'h0000, E_LSU,   16'h0310, 0, 16'h0000, 0, 16'h0000);
    vecs[4]  = mk(1, 16'h1104, 1, 0, 0, 16'h0314, 16'h0000, 0, 16'h0000, 16'h0000, E_FET,   16'h1104, 0, 16'h0000, 0, 16'h0000);
    vecs[5]  = mk(1, 16'h1108, 1, 0, 0, 16'h0314, 16'h0000, 0, 16'h0000, 16'h0000, E_LSU,   16'h0314, 0, 16'h0000, 0, 16'h0000);
    vecs[6]  = mk(0, 16'h0000, 1, 0, 1, 16'h0040, 16'h0000, 0, 16'h0000, 16'h0000, E_LSU,   16'h0040, 0, 16'h0000, 1, 16'h0040);
    vecs[7]  = mk(0, 16'h0000, 1, 1, 0, 16'h0040, 16'h1234, 0, 16'h0000, 16'h0000, E_STALL, 16'h0000, 0, 16'h0000, 1, 16'h0040);
    vecs[8]  = mk(1, 16'h2000, 1, 1, 0, 16'h0040, 16'h1234, 0, 16'h0000, 16'h0000, E_FET,   16'h2000, 0, 16'h0000, 1, 16'h0040);
    vecs[9]  = mk(1, 16'h2004, 1, 1, 0, 16'h0040, 16'h1234, 0, 16'h0000, 16'h0000, E_FET,   16'h2004, 0, 16'h0000, 1, 16'h0040);
    vecs[10] = mk(0, 16'h0000, 1, 0, 0, 16'h0041, 16'h0000, 0, 16'h0000, 16'h0000, E_LSU,   16'h0041, 0, 16'h0000, 1, 16'h0040);
    vecs[11] = mk(0, 16'h0000, 1, 1, 0, 16'h0040, 16'h1234, 1, 16'h0040, 16'hCAFE, E_RMW,   16'h0040, 1, 16'hCAFE, 0, 16'h0000);
    vecs[12] = mk(0, 16'h0000, 1, 1, 0, 16'h0040, 16'h1234, 0, 16'h0000, 16'h0000, E_LSU,   16'h0040, 1, 16'h1234, 0, 16'h0000);
    vecs[13] = mk(0, 16'h0000, 1, 0, 1, 16'h0040, 16'h0000, 0, 16'h0000, 16'h0000, E_LSU,   16'h0040, 0, 16'h0000, 1, 16'h0040);
    vecs[14] = mk(0, 16'h0000, 1, 0, 1, 16'h0050, 16'h0000, 0, 16'h0000, 16'h0000, E_STALL, 16'h0000, 0, 16'h0000, 1, 16'h0040);
    vecs[15] = mk(0, 16'h0000, 1, 0, 1, 16'h0050, 16'h0000, 1, 16'h0060, 16'h7777, E_RMW,   16'h0060, 1, 16'h7777, 1, 16'h0040);
    vecs[16] = mk(0, 16'h0000, 1, 0, 1, 16'h0050, 16'h0000, 1, 16'h0040, 16'h0BAD, E_RMW,   16'h0040, 1, 16'h0BAD, 0, 16'h0000);
    vecs[17] = mk(0, 16'h0000, 1, 0, 1, 16'h0050, 16'h0000, 0, 16'h0000, 16'h0000, E_LSU,   16'h0050, 0, 16'h0000, 1, 16'h0050);
    vecs[18] = mk(1, 16'h3000, 1, 0, 0, 16'h0070, 16'h0000, 1, 16'h0050, 16'h1111, E_RMW,   16'h0050, 1, 16'h1111, 0, 16'h0000);
    vecs[19] = mk(1, 16'h3000, 1, 0, 0, 16'h0070, 16'h0000, 0, 16'h0000, 16'h0000, E_FET,   16'h3000, 0, 16'h0000, 0, 16'h0000);
    vecs[20] = mk(0, 16'h0000, 1, 0, 0, 16'h0070, 16'h0000, 0, 16'h0000, 16'h0000, E_LSU,   16'h0070, 0, 16'h0000, 0, 16'h0000);
    vecs[21] = mk(0, 16'h0000, 1, 0, 1, 16'h0040, 16'h0000, 0, 16'h0000, 16'h0000, E_LSU,   16'h0040, 0, 16'h0000, 1, 16'h0040);

    rst_n = 1'b0; auto_rdy = 1'b1;
    drop_all();
    fet_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_we = 1'b0; lsu_rmw = 1'b0;
    rmw_addr = '0; rmw_data = '0;
    repeat (3) @(negedge clk);
    check_output("reset ctrl", 32'({mem_req, mem_we, fet_ack, lsu_ack, rmw_ack, lock_active}), 32'd0);
    check_output("reset mem_addr", 32'(mem_addr), 32'd0);
    check_output("reset mem_wdata", 32'(mem_wdata), 32'd0);
    check_output("reset lock_addr", 32'(lock_addr), 32'd0);
    check_output("reset rdata", 32'({fet_data, lsu_rdata}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i <= 20; i++) run_row(i);

    // Both held after an LSU service: FET, LSU, FET, LSU, three cycles apart.
    fet_req = 1'b1; fet_addr = 16'h1200;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_rmw = 1'b0; lsu_addr = 16'h0400;
    want[0] = 16'h1200; want[1] = 16'h0400; want[2] = 16'h1200; want[3] = 16'h0400;
    ngr = 0; prev = 1'b0;
    for (int c = 0; c < 20 && ngr < 4; c++) begin
      @(negedge clk);
      if (mem_req && !prev) begin gaddr[ngr] = mem_addr; gcyc[ngr] = c; ngr++; end
      prev = mem_req;
    end
    drop_all();
    check_output("rr grant_count", 32'(ngr), 32'd4);
    last_cyc = (ngr > 0) ? gcyc[0] : 0;
    for (int g = 0; g < ngr; g++) begin
      check_output($sformatf("rr addr%0d", g), 32'(gaddr[g]), 32'(want[g]));
      if (g > 0) check_output($sformatf("rr gap%0d", g), 32'(gcyc[g] - last_cyc), 32'd3);
      if (g > 0) last_cyc = gcyc[g];
    end
    repeat (4) @(negedge clk);

    run_row(21);

    // Memory holds off: request must stay stable until mem_rdy arrives.
    auto_rdy = 1'b0;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_rmw = 1'b0; lsu_addr = 16'h0123; lsu_wdata = 16'h4567;
    t = 0;
    while (!mem_req && t < 10) begin @(negedge clk); t++; end
    stable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!(mem_req && mem_we && mem_addr == 16'h0123 && mem_wdata == 16'h4567 && !lsu_ack))
        stable = 1'b0;
    end
    check_output("wait stable", 32'(stable), 32'd1);
    auto_rdy = 1'b1;
    t = 0;
    while (!lsu_ack && t < 10) begin @(negedge clk); t++; end
    check_output("wait lsu_ack", 32'(lsu_ack), 32'd1);
    drop_all();
    repeat (2) @(negedge clk);

    // Reset in the middle of a stalled fetch abandons it and clears the lock.
    auto_rdy = 1'b0;
    fet_req = 1'b1; fet_addr = 16'h5000;
    t = 0;
    while (!mem_req && t < 10) begin @(negedge clk); t++; end
    check_output("midrst busy", 32'(mem_req), 32'd1);
    drop_all();
    rst_n = 1'b0;
    @(negedge clk);
    check_output("midrst mem_req", 32'(mem_req), 32'd0);
    check_output("midrst lock", 32'(lock_active), 32'd0);
    rst_n = 1'b1; auto_rdy = 1'b1;
    ack_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (fet_ack || lsu_ack || rmw_ack || mem_req) ack_seen = 1'b1;
    end
    check_output("midrst no_ack", 32'(ack_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
